// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads one 16-bit word at pc, hands it to the
// control unit with a one-cycle start pulse, then waits for done before
// advancing pc (sequentially or to a branch target). A 16'hFFFF word halts the
// unit, and a memory that never acknowledges drives it into a sticky error.
module fetch_unit #(
    parameter int ADDR_W      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       inst,
    output logic              inst_valid,
    output logic              start,
    input  logic              done,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_HALT,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       inst_q, inst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // State, program counter, instruction register and ack-wait counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: run only matters in IDLE and at the end of EXEC, so an in-flight instruction always completes.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    inst_d  = mem_rdata;
                    state_d = (mem_rdata == HALT_WORD) ? S_HALT : S_ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (done) begin
                    pc_d = branch_en ? branch_addr : pc_q + ADDR_W'(1);
                    if (run) begin
                        state_d = S_FETCH;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded purely from the current state.
    always_comb begin
        mem_req    = 1'b0;
        start      = 1'b0;
        inst_valid = 1'b0;
        halted     = 1'b0;
        err        = 1'b0;
        case (state_q)
            S_FETCH: mem_req = 1'b1;
            S_ISSUE: begin
                start      = 1'b1;
                inst_valid = 1'b1;
            end
            S_EXEC:  inst_valid = 1'b1;
            S_HALT:  halted = 1'b1;
            S_ERROR: err = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign inst     = inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected instruction words are queued when the
// memory acknowledges and popped when the unit pulses start; pc is tracked by a
// small reference model updated at every done.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        memReq;
    logic [7:0]  memAddr;
    logic        memAck;
    logic [15:0] memRdata;
    logic [15:0] inst;
    logic        instValid;
    logic        start;
    logic        done;
    logic        branchEn;
    logic [7:0]  branchAddr;
    logic [7:0]  pc;
    logic        halted;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  modelPc = 8'h00;
    logic [15:0] expQ[$];

    fetch_unit #(.ADDR_W(8), .ACK_TIMEOUT(15)) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .mem_req(memReq),
        .mem_addr(memAddr),
        .mem_ack(memAck),
        .mem_rdata(memRdata),
        .inst(inst),
        .inst_valid(instValid),
        .start(start),
        .done(done),
        .branch_en(branchEn),
        .branch_addr(branchAddr),
        .pc(pc),
        .halted(halted),
        .err(err)
    );

    always #5 clk = ~clk;

    // Abort guard so a stuck sequence can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic runIn);
        reset = rst;
        run   = runIn;
    endtask

    // Currently in FETCH: withhold ack for 'misses' cycles, then deliver 'data'; ends in the first EXEC cycle.
    task automatic serveFetch(input logic [15:0] data, input int misses, input logic doneInIssue);
        logic [15:0] expInst;
        for (int i = 0; i < misses; i++) begin
            checkOutput("fetch_wait_req", {31'd0, memReq}, 32'd1);
            stepCycle();
        end
        checkOutput("fetch_req", {31'd0, memReq}, 32'd1);
        checkOutput("fetch_addr", {24'd0, memAddr}, {24'd0, modelPc});
        memAck   = 1'b1;
        memRdata = data;
        expQ.push_back(data);
        stepCycle();
        memAck   = 1'b0;
        memRdata = 16'($urandom);
        checkOutput("issue_start", {31'd0, start}, 32'd1);
        checkOutput("issue_valid", {31'd0, instValid}, 32'd1);
        checkOutput("issue_err", {31'd0, err}, 32'd0);
        if (expQ.size() == 0) begin
            checkOutput("sb_underflow", 32'd1, 32'd0);
        end else begin
            expInst = expQ.pop_front();
            checkOutput("issue_inst", {16'd0, inst}, {16'd0, expInst});
        end
        if (doneInIssue) begin
            done       = 1'b1;
            branchEn   = 1'b1;
            branchAddr = 8'hAA;
        end
        stepCycle();
        done     = 1'b0;
        branchEn = 1'b0;
        checkOutput("exec_start_low", {31'd0, start}, 32'd0);
        checkOutput("exec_valid", {31'd0, instValid}, 32'd1);
        checkOutput("exec_pc_hold", {24'd0, pc}, {24'd0, modelPc});
    endtask

    // Currently in EXEC: wait 'waitCycles', then signal done with the given branch and run values.
    task automatic finishExec(input int waitCycles, input logic br, input logic [7:0] addr, input logic runNext);
        logic [15:0] heldInst;
        heldInst = inst;
        run = runNext;
        for (int i = 0; i < waitCycles; i++) begin
            stepCycle();
            checkOutput("exec_inst_held", {16'd0, inst}, {16'd0, heldInst});
            checkOutput("exec_wait_valid", {31'd0, instValid}, 32'd1);
        end
        done       = 1'b1;
        branchEn   = br;
        branchAddr = addr;
        stepCycle();
        done     = 1'b0;
        branchEn = 1'b0;
        modelPc  = br ? addr : modelPc + 8'd1;
        checkOutput("next_pc", {24'd0, pc}, {24'd0, modelPc});
        if (runNext) begin
            checkOutput("next_req", {31'd0, memReq}, 32'd1);
            checkOutput("next_addr", {24'd0, memAddr}, {24'd0, modelPc});
        end else begin
            checkOutput("idle_req", {31'd0, memReq}, 32'd0);
            checkOutput("idle_valid", {31'd0, instValid}, 32'd0);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0);
        memAck     = 1'b0;
        memRdata   = 16'h0000;
        done       = 1'b0;
        branchEn   = 1'b0;
        branchAddr = 8'h00;
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 1'b0);
        stepCycle();
        checkOutput("rst_pc", {24'd0, pc}, 32'd0);
        checkOutput("rst_inst", {16'd0, inst}, 32'd0);
        checkOutput("rst_outs", {27'd0, memReq, start, instValid, halted, err}, 32'd0);

        // Basic latency: run in cycle 0, ack in cycle 1, start in cycle 2, done in cycle 5.
        run = 1'b1;
        stepCycle();
        serveFetch(16'h1234, 0, 1'b0);
        finishExec(2, 1'b0, 8'h00, 1'b1);

        // Branch taken, with a done in ISSUE that must be ignored.
        serveFetch(16'hABCD, 0, 1'b1);
        finishExec(0, 1'b1, 8'h40, 1'b1);

        // Wrap from 8'hFF to 8'h00.
        serveFetch(16'h2222, 0, 1'b0);
        finishExec(1, 1'b1, 8'hFF, 1'b1);
        serveFetch(16'h3333, 0, 1'b0);
        finishExec(0, 1'b0, 8'h00, 1'b1);

        // run dropped during EXEC: instruction completes, then IDLE.
        serveFetch(16'h0003, 0, 1'b0);
        finishExec(1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            memAck = 1'b1;
            stepCycle();
            checkOutput("idle_stays", {31'd0, memReq}, 32'd0);
        end
        memAck = 1'b0;
        checkOutput("idle_pc", {24'd0, pc}, 32'd1);

        // Ack on the last allowed cycle (14 misses) still issues normally.
        run = 1'b1;
        stepCycle();
        serveFetch(16'h5555, 14, 1'b0);
        finishExec(0, 1'b1, 8'h05, 1'b1);

        // Reset during EXEC at pc=5 with a simultaneous done.
        serveFetch(16'h6666, 0, 1'b0);
        checkOutput("pre_rst_pc", {24'd0, pc}, 32'd5);
        reset      = 1'b1;
        done       = 1'b1;
        branchEn   = 1'b1;
        branchAddr = 8'h77;
        stepCycle();
        reset    = 1'b0;
        done     = 1'b0;
        branchEn = 1'b0;
        modelPc  = 8'h00;
        checkOutput("exec_rst_pc", {24'd0, pc}, 32'd0);
        checkOutput("exec_rst_valid", {31'd0, instValid}, 32'd0);
        checkOutput("exec_rst_req", {31'd0, memReq}, 32'd0);
        checkOutput("exec_rst_inst", {16'd0, inst}, 32'd0);

        // Timeout: 15 cycles without ack gives a sticky error.
        stepCycle();
        for (int i = 0; i < 15; i++) begin
            checkOutput("to_req", {31'd0, memReq}, 32'd1);
            checkOutput("to_err_low", {31'd0, err}, 32'd0);
            stepCycle();
        end
        checkOutput("to_err", {31'd0, err}, 32'd1);
        checkOutput("to_req_low", {31'd0, memReq}, 32'd0);
        memAck   = 1'b1;
        memRdata = 16'h1111;
        stepCycle();
        memAck = 1'b0;
        stepCycle();
        checkOutput("to_sticky", {31'd0, err}, 32'd1);
        checkOutput("to_no_start", {31'd0, start}, 32'd0);

        // HALT word: sticky, no start, through 20 cycles with run high.
        applyStimulus(1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b1);
        checkOutput("rst_err_clear", {31'd0, err}, 32'd0);
        stepCycle();
        checkOutput("halt_fetch_req", {31'd0, memReq}, 32'd1);
        memAck   = 1'b1;
        memRdata = 16'hFFFF;
        stepCycle();
        memAck = 1'b0;
        for (int i = 0; i < 20; i++) begin
            done = 1'b1;
            checkOutput("halt_flag", {31'd0, halted}, 32'd1);
            checkOutput("halt_no_start", {31'd0, start}, 32'd0);
            checkOutput("halt_no_req", {31'd0, memReq}, 32'd0);
            stepCycle();
        end
        done = 1'b0;
        checkOutput("halt_pc", {24'd0, pc}, 32'd0);
        applyStimulus(1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0);
        checkOutput("halt_rst", {30'd0, halted, err}, 32'd0);

        checkOutput("sb_drain", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
